// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: extracts load data, selects the write-back source and
// registers the register-file write port, with stall, flush and a retired-instruction count.
module mem_wb_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        in_valid,
   input  logic        in_RegWrite,
   input  logic        in_MemToReg,
   input  logic        in_link,
   input  logic [2:0]  in_load_type,
   input  logic [1:0]  in_addr_lo,
   input  logic [31:0] in_alu_result,
   input  logic [31:0] in_mem_rdata,
   input  logic [31:0] in_pc_plus4,
   input  logic [4:0]  in_write_reg,
   output logic        RegWrite,
   output logic [31:0] write_back_data,
   output logic [4:0]  write_reg,
   output logic        wb_valid,
   output logic        misalign_err,
   output logic [31:0] retired_count
);

   typedef enum logic [2:0] {
      LdW  = 3'b000,
      LdB  = 3'b001,
      LdBu = 3'b010,
      LdH  = 3'b011,
      LdHu = 3'b100
   } load_e;

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_data;
   logic        is_word;
   logic        is_half;
   logic        mis;
   logic        we;
   logic [31:0] wb_data_d;

   logic        reg_write_q;
   logic [31:0] wb_data_q;
   logic [4:0]  write_reg_q;
   logic        wb_valid_q;
   logic        misalign_q;
   logic [31:0] retired_q;
   logic [31:0] retired_d;

   always_comb begin
      byte_sel = in_mem_rdata[7:0];
      unique case (in_addr_lo)
         2'd0: byte_sel = in_mem_rdata[7:0];
         2'd1: byte_sel = in_mem_rdata[15:8];
         2'd2: byte_sel = in_mem_rdata[23:16];
         2'd3: byte_sel = in_mem_rdata[31:24];
         default: byte_sel = in_mem_rdata[7:0];
      endcase
      half_sel = in_addr_lo[1] ? in_mem_rdata[31:16] : in_mem_rdata[15:0];
   end

   // Encodings 101-111 fall into the default arm and behave as lw.
   always_comb begin
      load_data = in_mem_rdata;
      is_word   = 1'b0;
      is_half   = 1'b0;
      case (load_e'(in_load_type))
         LdB:  load_data = {{24{byte_sel[7]}}, byte_sel};
         LdBu: load_data = {24'h0, byte_sel};
         LdH: begin
            load_data = {{16{half_sel[15]}}, half_sel};
            is_half   = 1'b1;
         end
         LdHu: begin
            load_data = {16'h0, half_sel};
            is_half   = 1'b1;
         end
         default: begin
            load_data = in_mem_rdata;
            is_word   = 1'b1;
         end
      endcase
   end

   always_comb begin
      mis = in_MemToReg & in_valid &
            ((is_word & (in_addr_lo != 2'b00)) | (is_half & in_addr_lo[0]));
      we  = in_valid & in_RegWrite & ~mis & (in_write_reg != 5'd0);

      if (in_link) begin
         wb_data_d = in_pc_plus4;
      end else if (in_MemToReg) begin
         wb_data_d = load_data;
      end else begin
         wb_data_d = in_alu_result;
      end

      retired_d = retired_q + 32'd1;
   end

   // Flush outranks stall; the counter only advances on a real, unstalled capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reg_write_q <= 1'b0;
         wb_data_q   <= 32'h0;
         write_reg_q <= 5'd0;
         wb_valid_q  <= 1'b0;
         misalign_q  <= 1'b0;
         retired_q   <= 32'h0;
      end else if (flush) begin
         reg_write_q <= 1'b0;
         wb_data_q   <= 32'h0;
         write_reg_q <= 5'd0;
         wb_valid_q  <= 1'b0;
         misalign_q  <= 1'b0;
      end else if (!stall) begin
         reg_write_q <= we;
         wb_data_q   <= wb_data_d;
         write_reg_q <= in_write_reg;
         wb_valid_q  <= in_valid;
         misalign_q  <= mis;
         if (in_valid) begin
            retired_q <= retired_d;
         end
      end
   end

   assign RegWrite        = reg_write_q;
   assign write_back_data = wb_data_q;
   assign write_reg       = write_reg_q;
   assign wb_valid        = wb_valid_q;
   assign misalign_err    = misalign_q;
   assign retired_count   = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expected outputs are queued as stimulus is driven
// and compared one cycle later, after the capturing edge.
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        flush;
   logic        in_valid;
   logic        in_RegWrite;
   logic        in_MemToReg;
   logic        in_link;
   logic [2:0]  in_load_type;
   logic [1:0]  in_addr_lo;
   logic [31:0] in_alu_result;
   logic [31:0] in_mem_rdata;
   logic [31:0] in_pc_plus4;
   logic [4:0]  in_write_reg;
   logic        RegWrite;
   logic [31:0] write_back_data;
   logic [4:0]  write_reg;
   logic        wb_valid;
   logic        misalign_err;
   logic [31:0] retired_count;

   typedef struct packed {
      logic        rw;
      logic [31:0] data;
      logic [4:0]  wr;
      logic        v;
      logic        mis;
      logic [31:0] cnt;
   } out_t;

   out_t        sb[$];
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] cnt      = 32'h0;

   always #5 clk = ~clk;

   mem_wb_stage dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .flush          (flush),
      .in_valid       (in_valid),
      .in_RegWrite    (in_RegWrite),
      .in_MemToReg    (in_MemToReg),
      .in_link        (in_link),
      .in_load_type   (in_load_type),
      .in_addr_lo     (in_addr_lo),
      .in_alu_result  (in_alu_result),
      .in_mem_rdata   (in_mem_rdata),
      .in_pc_plus4    (in_pc_plus4),
      .in_write_reg   (in_write_reg),
      .RegWrite       (RegWrite),
      .write_back_data(write_back_data),
      .write_reg      (write_reg),
      .wb_valid       (wb_valid),
      .misalign_err   (misalign_err),
      .retired_count  (retired_count)
   );

   function automatic out_t observe();
      return out_t'({RegWrite, write_back_data, write_reg, wb_valid, misalign_err, retired_count});
   endfunction

   task automatic drive(input logic v, input logic rw, input logic mtr, input logic lk,
                        input logic [2:0] lt, input logic [1:0] lo, input logic [31:0] alu,
                        input logic [4:0] wr, input logic st, input logic fl,
                        input logic erw, input logic [31:0] ed, input logic [4:0] ewr,
                        input logic ev, input logic emis);
      out_t e;
      in_valid      = v;
      in_RegWrite   = rw;
      in_MemToReg   = mtr;
      in_link       = lk;
      in_load_type  = lt;
      in_addr_lo    = lo;
      in_alu_result = alu;
      in_write_reg  = wr;
      stall         = st;
      flush         = fl;
      if (v && !st && !fl) cnt = cnt + 32'd1;
      e = '{rw: erw, data: ed, wr: ewr, v: ev, mis: emis, cnt: cnt};
      sb.push_back(e);
   endtask

   task automatic idle_inputs();
      stall = 0; flush = 0; in_valid = 0; in_RegWrite = 0; in_MemToReg = 0; in_link = 0;
      in_load_type = 0; in_addr_lo = 0; in_alu_result = 0; in_mem_rdata = 0;
      in_pc_plus4 = 0; in_write_reg = 0;
   endtask

   task automatic test_reset();
      out_t o, e;
      idle_inputs();
      reset = 1;
      repeat (2) @(posedge clk);
      #1;
      o = observe();
      checks++;
      if (o !== '0) begin
         failures++; $display("FAIL reset_held: got %h want 0", o);
      end
      reset = 0;
      drive(1, 1, 0, 0, 3'b000, 2'b00, 32'h1234_5678, 5'd4, 0, 0,
            1, 32'h1234_5678, 5'd4, 1, 0);
      @(posedge clk); #1;
      e = sb.pop_front(); o = observe();
      checks++;
      if (o !== e) begin
         failures++; $display("FAIL reset_first_capture: got %h want %h", o, e);
      end
      #2 reset = 1;
      #1;
      o = observe();
      checks++;
      if (o !== '0) begin
         failures++; $display("FAIL reset_async: got %h want 0", o);
      end
      @(posedge clk); #1;
      o = observe();
      checks++;
      if (o !== '0) begin
         failures++; $display("FAIL reset_over_edge: got %h want 0", o);
      end
      reset = 0;
      cnt = 0;
      sb.delete();
   endtask

   task automatic test_loads();
      logic [2:0]  lt_t [10] = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b011,
                                 3'b100, 3'b011, 3'b000, 3'b101, 3'b001};
      logic [1:0]  lo_t [10] = '{2'd1, 2'd1, 2'd3, 2'd3, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
      logic [31:0] ex_t [10] = '{32'h0000_007F, 32'h0000_007F, 32'hFFFF_FF80, 32'h0000_0080,
                                 32'hFFFF_80F1, 32'h0000_80F1, 32'h0000_7F01, 32'h80F1_7F01,
                                 32'h80F1_7F01, 32'h0000_0001};
      out_t o, e;
      in_mem_rdata = 32'h80F1_7F01;
      for (int i = 0; i < 10; i++) begin
         drive(1, 1, 1, 0, lt_t[i], lo_t[i], 32'hCAFE_0000, 5'(i + 3), 0, 0,
               1, ex_t[i], 5'(i + 3), 1, 0);
         @(posedge clk); #1;
         e = sb.pop_front(); o = observe();
         checks++;
         if (o !== e) begin
            failures++; $display("FAIL load[%0d]: got %h want %h", i, o, e);
         end
      end
   endtask

   task automatic test_misalign();
      logic        v_t   [5] = '{1, 1, 1, 1, 0};
      logic        mtr_t [5] = '{1, 1, 1, 0, 1};
      logic [2:0]  lt_t  [5] = '{3'b000, 3'b011, 3'b100, 3'b000, 3'b000};
      logic [1:0]  lo_t  [5] = '{2'd2, 2'd1, 2'd3, 2'd1, 2'd2};
      logic [31:0] ed_t  [5] = '{32'h80F1_7F01, 32'h0000_7F01, 32'h0000_80F1,
                                 32'h1234_5679, 32'h80F1_7F01};
      logic        erw_t [5] = '{0, 0, 0, 1, 0};
      logic        mis_t [5] = '{1, 1, 1, 0, 0};
      out_t o, e;
      in_mem_rdata = 32'h80F1_7F01;
      for (int i = 0; i < 5; i++) begin
         drive(v_t[i], 1, mtr_t[i], 0, lt_t[i], lo_t[i], 32'h1234_5679, 5'd9, 0, 0,
               erw_t[i], ed_t[i], 5'd9, v_t[i], mis_t[i]);
         @(posedge clk); #1;
         e = sb.pop_front(); o = observe();
         checks++;
         if (o !== e) begin
            failures++; $display("FAIL misalign[%0d]: got %h want %h", i, o, e);
         end
      end
   endtask

   task automatic test_source();
      logic        rw_t  [4] = '{1, 1, 1, 0};
      logic        mtr_t [4] = '{1, 0, 0, 0};
      logic        lk_t  [4] = '{1, 0, 1, 0};
      logic [4:0]  wr_t  [4] = '{5'd31, 5'd0, 5'd2, 5'd5};
      logic [31:0] ed_t  [4] = '{32'h0040_0010, 32'hDEAD_BEEF, 32'h0040_0010, 32'hDEAD_BEEF};
      logic        erw_t [4] = '{1, 0, 1, 0};
      out_t o, e;
      in_mem_rdata = 32'h80F1_7F01;
      in_pc_plus4  = 32'h0040_0010;
      for (int i = 0; i < 4; i++) begin
         drive(1, rw_t[i], mtr_t[i], lk_t[i], 3'b000, 2'd0, 32'hDEAD_BEEF, wr_t[i], 0, 0,
               erw_t[i], ed_t[i], wr_t[i], 1, 0);
         @(posedge clk); #1;
         e = sb.pop_front(); o = observe();
         checks++;
         if (o !== e) begin
            failures++; $display("FAIL source[%0d]: got %h want %h", i, o, e);
         end
      end
   endtask

   task automatic test_stall_flush();
      out_t o, e;
      in_mem_rdata = 32'h0;
      drive(1, 1, 0, 0, 3'b000, 2'd0, 32'hA5A5_0001, 5'd7, 0, 0, 1, 32'hA5A5_0001, 5'd7, 1, 0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         e = sb.pop_front(); o = observe();
         checks++;
         if (o !== e) begin
            failures++; $display("FAIL stall_flush[%0d]: got %h want %h", i, o, e);
         end
         if (i < 3) begin
            // Stall with changing inputs: A must be held.
            drive(1, 1, 0, 0, 3'b000, 2'd0, 32'h0000_1000 + 32'(i), 5'd9, 1, 0,
                  1, 32'hA5A5_0001, 5'd7, 1, 0);
         end else if (i == 3) begin
            drive(1, 1, 0, 0, 3'b000, 2'd0, 32'h0000_2000, 5'd9, 1, 1, 0, 32'h0, 5'd0, 0, 0);
         end
      end
      drive(1, 1, 0, 0, 3'b000, 2'd0, 32'h0000_3000, 5'd10, 0, 1, 0, 32'h0, 5'd0, 0, 0);
      @(posedge clk); #1;
      e = sb.pop_front(); o = observe();
      checks++;
      if (o !== e) begin
         failures++; $display("FAIL flush_only: got %h want %h", o, e);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a;
      logic [4:0]  r;
      out_t        o, e;
      for (int i = 0; i < 8; i++) begin
         a = $urandom();
         r = 5'($urandom_range(31, 1));
         drive(1, 1, 0, 0, 3'b000, 2'd0, a, r, 0, 0, 1, a, r, 1, 0);
         @(posedge clk); #1;
         e = sb.pop_front(); o = observe();
         checks++;
         if (o !== e) begin
            failures++; $display("FAIL b2b[%0d]: got %h want %h", i, o, e);
         end
      end
   endtask

   task automatic test_reset_mid_stall();
      out_t o, e;
      drive(1, 1, 0, 0, 3'b000, 2'd0, 32'h0BAD_F00D, 5'd12, 0, 0, 1, 32'h0BAD_F00D, 5'd12, 1, 0);
      @(posedge clk); #1;
      e = sb.pop_front(); o = observe();
      checks++;
      if (o !== e) begin
         failures++; $display("FAIL rst_stall_pre: got %h want %h", o, e);
      end
      stall = 1;
      #2 reset = 1;
      #1;
      o = observe();
      checks++;
      if (o !== '0) begin
         failures++; $display("FAIL rst_stall_async: got %h want 0", o);
      end
      @(posedge clk); #1;
      reset = 0;
      cnt = 0;
      drive(0, 1, 0, 0, 3'b000, 2'd0, 32'h0, 5'd0, 0, 0, 0, 32'h0, 5'd0, 0, 0);
      @(posedge clk); #1;
      e = sb.pop_front(); o = observe();
      checks++;
      if (o !== e) begin
         failures++; $display("FAIL rst_stall_after: got %h want %h", o, e);
      end
   endtask

   task automatic test_wrap();
      out_t o, e;
      force dut.retired_q = 32'hFFFF_FFFF;
      #1 release dut.retired_q;
      cnt = 32'hFFFF_FFFF;
      drive(1, 1, 0, 0, 3'b000, 2'd0, 32'h5555_AAAA, 5'd1, 0, 0, 1, 32'h5555_AAAA, 5'd1, 1, 0);
      @(posedge clk); #1;
      e = sb.pop_front(); o = observe();
      checks++;
      if (o !== e || retired_count !== 32'h0) begin
         failures++; $display("FAIL wrap: got %h want %h", o, e);
      end
      drive(1, 1, 0, 0, 3'b000, 2'd0, 32'h6666_BBBB, 5'd2, 0, 0, 1, 32'h6666_BBBB, 5'd2, 1, 0);
      @(posedge clk); #1;
      e = sb.pop_front(); o = observe();
      checks++;
      if (o !== e || retired_count !== 32'h1) begin
         failures++; $display("FAIL wrap_next: got %h want %h", o, e);
      end
   endtask

   initial begin
      test_reset();
      test_loads();
      test_misalign();
      test_source();
      test_stall_flush();
      test_back_to_back();
      test_reset_mid_stall();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
